// File: rtl/sigma_bus_arb2.sv
// sigma_bus_arb2: two-master / one-slave round-robin bus arbiter with hold limit and in-order read-response routing.
// Define SIGMA_BUS_ARB_LOCK_EN to add m0_lock_i for atomic CPU read-modify-write sequences.
`timescale 1ns/1ps
module sigma_bus_arb2 #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int OUTST    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_ack_o,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
`ifdef SIGMA_BUS_ARB_LOCK_EN
    input  logic                m0_lock_i,
`endif
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_ack_o,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_i
);

    localparam int BE_W   = DATA_W / 8;
    localparam int PTR_W  = $clog2(OUTST);
    localparam int CNT_W  = $clog2(OUTST + 1);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    cmd_t [1:0]        cmd;
    cmd_t              sel;
    logic              prio_q, last_q, last_vld_q;
    logic [HOLD_W-1:0] hold_cnt_q, hold_next;
    logic [OUTST-1:0]  id_mem;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              fifo_full, fifo_empty, can_grant;
    logic              gnt, win, accept, push, pop, resp_vld, head_id;
    logic              m1_block, lock_hold, req1, other_req;

    assign cmd[0] = '{we: m0_we_i, addr: m0_addr_i, be: m0_be_i, wdata: m0_wdata_i};
    assign cmd[1] = '{we: m1_we_i, addr: m1_addr_i, be: m1_be_i, wdata: m1_wdata_i};

`ifdef SIGMA_BUS_ARB_LOCK_EN
    // Lock only bites once master 0 actually owns the bus.
    assign m1_block  = m0_lock_i & last_vld_q & ~last_q;
    assign lock_hold = m0_lock_i & ~win;
`else
    assign m1_block  = 1'b0;
    assign lock_hold = 1'b0;
`endif

    assign fifo_full  = (count_q == CNT_W'(OUTST));
    assign fifo_empty = (count_q == '0);
    // A same-cycle pop frees the slot, so a full FIFO still grants while a response arrives.
    assign can_grant  = ~fifo_full | s_resp_i;
    assign req1       = m1_req_i & ~m1_block;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = 1'b0;
        win = 1'b0;
        if (!arst_i && can_grant) begin
            if (m0_req_i && req1) begin
                gnt = 1'b1;
                win = prio_q;
            end else if (m0_req_i) begin
                gnt = 1'b1;
            end else if (req1) begin
                gnt = 1'b1;
                win = 1'b1;
            end
        end
    end

    assign sel       = gnt ? cmd[win] : '0;
    assign s_req_o   = gnt;
    assign s_we_o    = sel.we;
    assign s_addr_o  = sel.addr;
    assign s_be_o    = sel.be;
    assign s_wdata_o = sel.wdata;

    assign accept    = gnt & s_ack_i;
    assign m0_ack_o  = accept & ~win;
    assign m1_ack_o  = accept & win;
    assign push      = accept & ~sel.we;
    assign other_req = win ? m0_req_i : m1_req_i;

    assign hold_next = (last_vld_q && (win == last_q))
                     ? ((hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1))
                     : HOLD_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            prio_q     <= 1'b0;
            last_q     <= 1'b0;
            last_vld_q <= 1'b0;
            hold_cnt_q <= '0;
        end else if (accept) begin
            prio_q     <= ~win;
            last_q     <= win;
            last_vld_q <= 1'b1;
            if (other_req && !lock_hold && hold_next == HOLD_MAX)
                hold_cnt_q <= '0;
            else
                hold_cnt_q <= hold_next;
        end
    end

    assign head_id  = id_mem[rd_ptr_q];
    // Responses with nothing outstanding are dropped rather than underflowing the FIFO.
    assign resp_vld = s_resp_i & ~fifo_empty & ~arst_i;
    assign pop      = resp_vld;

    assign m0_resp_o  = resp_vld & ~head_id;
    assign m1_resp_o  = resp_vld & head_id;
    assign m0_rdata_o = m0_resp_o ? s_rdata_i : '0;
    assign m1_rdata_o = m1_resp_o ? s_rdata_i : '0;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: ID storage is not reset; entries are only read once count_q proves them valid.
    always_ff @(posedge clk_i) begin
        if (push)
            id_mem[wr_ptr_q] <= win;
    end

endmodule

// File: doc/sigma_bus_arb2.md
Name: sigma_bus_arb2

Overview:
- Two-master, one-slave arbiter for the sigma SoC data bus.
- Shares the single data-memory/peripheral port between the CPU data interface (master 0) and the UART debug/loader host (master 1).
- Uses round-robin arbitration with a hold limit.
- Tracks outstanding reads in an ID FIFO so each slave response is routed back to the master that issued it, in order.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- OUTST, 4, maximum outstanding reads; power of two, minimum 2.
- MAX_HOLD, 8, maximum consecutive grants to one master while the other is requesting.

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  asynchronous reset, active-high.
- mN_req_i  in  1  master N request (N = 0, 1).
- mN_we_i  in  1  master N write enable.
- mN_addr_i  in  ADDR_W  master N address.
- mN_be_i  in  DATA_W/8  master N byte enables.
- mN_wdata_i  in  DATA_W  master N write data.
- mN_ack_o  out  1  master N command accepted.
- mN_resp_o  out  1  master N read data valid.
- mN_rdata_o  out  DATA_W  master N read data.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  ADDR_W  slave address.
- s_be_o  out  DATA_W/8  slave byte enables.
- s_wdata_o  out  DATA_W  slave write data.
- s_ack_i  in  1  slave command accepted.
- s_resp_i  in  1  slave read data valid.
- s_rdata_i  in  DATA_W  slave read data.

Behaviour:

Bus protocol
- A command transfers in the cycle where req and ack are both high.
- A master holds req, we, addr, be and wdata stable until it sees ack.
- Reads return exactly one resp pulse later, in issue order.
- Writes produce no response.

Grant selection (combinational, each cycle)
- Only one master requests: that master wins.
- Both request: winner is the master pointed to by prio_q.
- FIFO full: no grant; s_req_o = 0 regardless of requests.

Slave-side outputs
- s_* command signals are muxed from the winning master.
- When there is no grant, s_req_o = 0 and s_we_o/s_addr_o/s_be_o/s_wdata_o = 0.

Accept
- mN_ack_o = s_ack_i & s_req_o & (winner == N); the non-winning master's ack is 0.

prio_q update (only on an accepted transfer)
- Winner is the same as the previous accepted winner: hold_cnt increments.
- Otherwise hold_cnt = 1.
- The other master is requesting and hold_cnt reaches MAX_HOLD: prio_q points to the other master and hold_cnt = 0.
- Otherwise prio_q points to the master that did not win, i.e. plain round-robin alternation.
- With only one master active, that master is granted back-to-back with no bubble.

ID FIFO (OUTST entries, 1-bit master ID)
- Push on every accepted read (winner ID).
- Pop on s_resp_i.
- Responses route combinationally to the FIFO head ID: mH_resp_o = s_resp_i; mH_rdata_o = s_rdata_i.
- The other master sees resp = 0 and rdata = 0.
- Push and pop in the same cycle are both performed; the count is unchanged.
- An accepted read while full is impossible (grant masked).
- s_resp_i while the FIFO is empty is a slave protocol error: the response is dropped, no master sees it, and the count stays 0 (no underflow).

Latency
- Zero added cycles on both the command and response paths; purely combinational muxing plus registered state.

Reset (arst_i high, asynchronous)
- prio_q = master 0, hold_cnt = 0, FIFO empty (pointers and count 0).
- All outputs 0 while arst_i is asserted.
- Reset mid-transaction drops all outstanding IDs. Slave and masters are reset by the same arst_i, so no stale responses arrive.

Optional Feature:
- Macro SIGMA_BUS_ARB_LOCK_EN.
- Defined:
  - Adds port m0_lock_i (in, 1).
  - While m0_lock_i = 1 and the last accepted transfer was from master 0, master 1 is never granted.
  - MAX_HOLD is ignored for master 0, allowing atomic read-modify-write sequences from the CPU.
  - The lock is released when m0_lock_i drops; normal round-robin resumes next cycle with prio_q = master 1.
- Undefined: the port does not exist and arbitration is as above.

Test Plan:
- Single master: m0 issues 5 reads to 0x100..0x110, s_ack_i tied 1, slave responds 1 cycle later -> m0_ack_o high 5 consecutive cycles; m0_resp_o returns 5 data words in order; m1 outputs stay 0.
- Contention: m0 and m1 both hold req with s_ack_i = 1 -> grants alternate m0, m1, m0, m1 (prio_q = 0 after reset); each master receives only its own read data.
- FIFO full: OUTST = 4, 4 reads accepted with no response -> s_req_o = 0 on the 5th request; first s_resp_i pops one entry and s_req_o reasserts the same cycle.
- Hold limit: MAX_HOLD = 8 with m1 continuously requesting and prio forced to m0 via reset (m1 request rising after m0's first grant) -> m0 gets no more than 8 consecutive grants before m1 is granted.
- Reset mid-flight: 2 reads outstanding, assert arst_i for 1 cycle -> all outputs 0 immediately; FIFO empty; first grant after release goes to m0 when both request.
- Lock (SIGMA_BUS_ARB_LOCK_EN defined): m0_lock_i = 1, m0 read then write to 0x200 while m1 requests -> m1_ack_o = 0 until lock drops; m1 granted the next cycle after.
